aes_round_ctrl: RTL and testbench

Iterative AES-128 encryption sequencer. It owns the 128-bit state register and steps one external round datapath (SubBytes -> ShiftRows -> MixColumns -> AddRoundKey, with MixColumns bypassed on the final round) once per clock. It requests round keys by index from an external key store and exchanges blocks with upstream and downstream logic over valid/ready handshakes.

---
 rtl/aes_round_ctrl.sv | 114 +++++++++++
 tb/tb_aes_round_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryption sequencer.
// Owns the 128-bit state register and steps an external round datapath once per clock.
// It addresses an external key store by round index.
// Optional build macro AES_KEY_STALL_EN adds rndKeyValid. Each cycle with rndKeyValid low
// blocks accept and freezes round progress.
module aes_round_ctrl #(
  parameter int NR      = 10,
  parameter int ROUND_W = 4
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               inValid,
  output logic               inReady,
  input  logic [127:0]       inData,
  input  logic [127:0]       rndKey,
`ifdef AES_KEY_STALL_EN
  input  logic               rndKeyValid,
`endif
  output logic [ROUND_W-1:0] rdRound,
  output logic               rdLast,
  output logic [127:0]       rdState,
  input  logic [127:0]       rdResult,
  output logic               outValid,
  input  logic               outReady,
  output logic [127:0]       outData,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ROUND_W-1:0] LAST_ROUND  = ROUND_W'(NR);
  localparam logic [ROUND_W-1:0] FIRST_ROUND = ROUND_W'(1);

  state_t               state, state_nxt;
  logic [127:0]         state_reg, state_reg_nxt;
  logic [ROUND_W-1:0]   round, round_nxt;
  logic                 key_ok;
  logic                 in_ready;
  logic                 out_valid;
  logic                 last;

`ifdef AES_KEY_STALL_EN
  assign key_ok = rndKeyValid;
`else
  assign key_ok = 1'b1;
`endif

  // Control and block state registers; reset drops any in-flight block at once.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      state_reg <= '0;
      round     <= '0;
    end else begin
      state     <= state_nxt;
      state_reg <= state_reg_nxt;
      round     <= round_nxt;
    end
  end

  // Sequencing: initial AddRoundKey on accept, one round per cycle, and hold in DONE until drained.
  always_comb begin
    state_nxt     = state;
    state_reg_nxt = state_reg;
    round_nxt     = round;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    last          = 1'b0;
    case (state)
      IDLE: begin
        in_ready = key_ok;
        if (inValid && key_ok) begin
          state_reg_nxt = inData ^ rndKey;
          round_nxt     = FIRST_ROUND;
          state_nxt     = ROUND;
        end
      end
      ROUND: begin
        last = (round == LAST_ROUND);
        if (key_ok) begin
          state_reg_nxt = rdResult;
          if (round == LAST_ROUND) begin
            state_nxt = DONE;
          end else begin
            round_nxt = round + FIRST_ROUND;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (outReady) begin
          round_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign inReady  = in_ready;
  assign outValid = out_valid;
  assign rdLast   = last;
  assign rdRound  = round;
  assign rdState  = state_reg;
  assign outData  = state_reg;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl. It supplies the FIPS-197 key schedule and a behavioural AES round datapath.
// A cycle-level protocol model is compared against the DUT on every cycle, and
// directed FIPS-197 vectors pin the ciphertexts.
module tb_aes_round_ctrl;
  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rstN;
  logic         inValid = 1'b0;
  logic         outReady = 1'b0;
  logic         key_valid = 1'b1;
  logic [127:0] inData = '0;
  logic [127:0] rndKey;
  logic [127:0] rdResult;
  logic         inReady, rdLast, outValid, busy;
  logic [3:0]   rdRound;
  logic [127:0] rdState, outData;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int last_cnt = 0;

  logic [127:0] rk [0:10];

  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_ZERO = 128'hc6a13b37878f5b826f4f8162a1c8d879;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(NR), .ROUND_W(4)) dut (
    .clk(clk),
    .rstN(rstN),
    .inValid(inValid),
    .inReady(inReady),
    .inData(inData),
    .rndKey(rndKey),
`ifdef AES_KEY_STALL_EN
    .rndKeyValid(key_valid),
`endif
    .rdRound(rdRound),
    .rdLast(rdLast),
    .rdState(rdState),
    .rdResult(rdResult),
    .outValid(outValid),
    .outReady(outReady),
    .outData(outData),
    .busy(busy)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] b;
    int e;
    r = 8'h01;
    b = x;
    e = 254;
    while (e != 0) begin
      if ((e % 2) == 1) r = gmul(r, b);
      b = gmul(b, b);
      e = e / 2;
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // One AES round on a column-major block, byte 0 in the top bits.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] m [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[c*4+r] = b[((c+r)%4)*4+r];
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        for (int r = 0; r < 4; r++) m[c*4+r] = t[c*4+r];
      end else begin
        m[c*4+0] = gmul(8'h02, t[c*4]) ^ gmul(8'h03, t[c*4+1]) ^ t[c*4+2] ^ t[c*4+3];
        m[c*4+1] = t[c*4] ^ gmul(8'h02, t[c*4+1]) ^ gmul(8'h03, t[c*4+2]) ^ t[c*4+3];
        m[c*4+2] = t[c*4] ^ t[c*4+1] ^ gmul(8'h02, t[c*4+2]) ^ gmul(8'h03, t[c*4+3]);
        m[c*4+3] = gmul(8'h03, t[c*4]) ^ t[c*4+1] ^ t[c*4+2] ^ gmul(8'h02, t[c*4+3]);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = m[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r <= NR; r++) s = aes_round(s, rk[r], r == NR);
    return s;
  endfunction

  // Key store and round datapath seen by the DUT.
  assign rndKey   = (rdRound <= 4'd10) ? rk[rdRound] : 128'h0;
  assign rdResult = aes_round(rdState, rndKey, rdLast);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Protocol model: 0 = waiting for a block, 1 = running rounds, 2 = holding ciphertext.
  int           m_phase;
  int           m_round;
  logic [127:0] m_state;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      m_phase <= 0;
      m_round <= 0;
      m_state <= '0;
    end else begin
      case (m_phase)
        0: if (inValid && key_valid) begin
             m_state <= inData ^ rk[0];
             m_round <= 1;
             m_phase <= 1;
           end
        1: if (key_valid) begin
             m_state <= aes_round(m_state, rk[m_round], m_round == NR);
             if (m_round == NR) m_phase <= 2;
             else m_round <= m_round + 1;
           end
        default: if (outReady) begin
             m_phase <= 0;
             m_round <= 0;
           end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rstN) begin
      chk("in_ready", inReady, (m_phase == 0) && key_valid);
      chk("busy", busy, m_phase != 0);
      chk("out_valid", outValid, m_phase == 2);
      chk("rd_last", rdLast, (m_phase == 1) && (m_round == NR));
      chk("rd_round", rdRound, 128'(m_round));
      chk("rd_state", rdState, m_state);
      chk("out_data", outData, m_state);
      if (rdLast) last_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic send(input logic [127:0] d);
    int n;
    inData = d;
    inValid = 1'b1;
    n = 0;
    while (!inReady && n < 50) begin
      tick();
      n++;
    end
    acc_cyc = cyc;
    tick();
    inValid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output logic [127:0] d);
    int n;
    n = 0;
    while (!outValid && n < 60) begin
      tick();
      n++;
    end
    chk("out_timeout", outValid, 1'b1);
    lat = cyc - acc_cyc;
    d = outData;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] key;
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rcon;
    logic [127:0] d, d0, st;
    logic [7:0]   sb_in;
    int lat;
    int n;

    key = 128'h000102030405060708090a0b0c0d0e0f;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]) ^ rcon, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

    // Pin the reference model with published values.
    sb_in = 8'h53;
    chk("sbox_53", sbox(sb_in), 8'hed);
    chk("rk10", rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("model_c1", aes_encrypt(PT_C1), CT_C1);
    chk("model_zero", aes_encrypt(128'h0), CT_ZERO);

    // Reset state.
    rstN = 1'b1;
    #1 rstN = 1'b0;
    #2;
    chk("rst_in_ready", inReady, 1'b1);
    chk("rst_out_valid", outValid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_round", rdRound, 4'd0);
    chk("rst_rd_last", rdLast, 1'b0);
    chk("rst_out_data", outData, 128'h0);
    tick();
    tick();
    rstN = 1'b1;
    tick();

    // FIPS-197 C.1 with the sink always ready.
    outReady = 1'b1;
    last_cnt = 0;
    send(PT_C1);
    wait_out(lat, d);
    chk("c1_latency", lat, 11);
    chk("c1_data", d, CT_C1);
    chk("c1_last_cycles", last_cnt, 1);
    tick();
    chk("c1_idle_after", inReady, 1'b1);

    // Output backpressure.
    outReady = 1'b0;
    send(PT_C1);
    wait_out(lat, d0);
    chk("bp_data", d0, CT_C1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", outValid, 1'b1);
      chk("bp_hold_data", outData, d0);
      chk("bp_hold_round", rdRound, 4'd10);
      chk("bp_hold_in_ready", inReady, 1'b0);
    end
    outReady = 1'b1;
    tick();
    chk("bp_rel_in_ready", inReady, 1'b1);
    chk("bp_rel_out_valid", outValid, 1'b0);
    chk("bp_rel_busy", busy, 1'b0);

    // Back-to-back with inValid held high.
    inData = PT_C1;
    inValid = 1'b1;
    acc_cyc = cyc;
    tick();
    inData = 128'h0;
    wait_out(lat, d);
    chk("b2b_first", d, CT_C1);
    tick();
    chk("b2b_second_ready", inReady, 1'b1);
    acc_cyc = cyc;
    tick();
    inValid = 1'b0;
    wait_out(lat, d);
    chk("b2b_second_latency", lat, 11);
    chk("b2b_second", d, CT_ZERO);
    tick();

    // Asynchronous reset in the middle of a block.
    send(PT_C1);
    n = 0;
    while (rdRound != 4'd5 && n < 20) begin
      tick();
      n++;
    end
    chk("mid_round_reached", rdRound, 4'd5);
    #1 rstN = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_out_valid", outValid, 1'b0);
    chk("mid_rst_rd_round", rdRound, 4'd0);
    chk("mid_rst_state", rdState, 128'h0);
    chk("mid_rst_in_ready", inReady, 1'b1);
    tick();
    rstN = 1'b1;
    tick();
    send(PT_C1);
    wait_out(lat, d);
    chk("post_rst_data", d, CT_C1);
    chk("post_rst_latency", lat, 11);
    tick();

    // Garbage on the input while rounds are running.
    send(PT_C1);
    for (int i = 0; i < 8; i++) begin
      inValid = i[0];
      inData = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    inValid = 1'b0;
    wait_out(lat, d);
    chk("ignored_in_data", d, CT_C1);
    chk("ignored_in_latency", lat, 11);
    tick();

`ifdef AES_KEY_STALL_EN
    // Key store stalls for three cycles at round 4.
    send(PT_C1);
    n = 0;
    while (rdRound != 4'd4 && n < 20) begin
      tick();
      n++;
    end
    st = rdState;
    key_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_round", rdRound, 4'd4);
      chk("stall_state", rdState, st);
    end
    key_valid = 1'b1;
    wait_out(lat, d);
    chk("stall_latency", lat, 14);
    chk("stall_data", d, CT_C1);
    tick();
`else
    st = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
